// File: rtl/wb_gpio_port_irq.sv
// Wishbone GPIO port: per-pin direction, atomic set/clear of outputs, N-stage input
// synchroniser and per-pin edge interrupts folded into one registered level irq.
module wb_gpio_port_irq #(
  parameter int g_num_pins    = 32,
  parameter int g_sync_stages = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n_i,
  input  logic [2:0]            wb_addr_i,
  input  logic [31:0]           wb_data_i,
  output logic [31:0]           wb_data_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  input  logic [g_num_pins-1:0] gpio_in_i,
  output logic [g_num_pins-1:0] gpio_out_o,
  output logic [g_num_pins-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int W = g_num_pins;

  localparam logic [2:0] A_SOPR  = 3'd0;
  localparam logic [2:0] A_COPR  = 3'd1;
  localparam logic [2:0] A_PDR   = 3'd2;
  localparam logic [2:0] A_DDR   = 3'd3;
  localparam logic [2:0] A_PSR   = 3'd4;
  localparam logic [2:0] A_IER   = 3'd5;
  localparam logic [2:0] A_IEDGE = 3'd6;
  localparam logic [2:0] A_ISR   = 3'd7;

  logic [W-1:0]  r_out;
  logic [W-1:0]  r_ddr;
  logic [W-1:0]  r_ier;
  logic [W-1:0]  r_iedge;
  logic [W-1:0]  r_isr;
  logic [W-1:0]  r_prev;
  logic [W-1:0]  r_sync [g_sync_stages];
  logic          r_ack;
  logic          r_irq;
  logic [31:0]   r_rdata;

  logic          w_req;
  logic          w_wr;
  logic          w_rd;
  logic [W-1:0]  w_wdata;
  logic [W-1:0]  w_psr;
  logic [W-1:0]  w_edge;
  logic [W-1:0]  w_isr_clr;
  logic [W-1:0]  w_rd_word;
  logic          w_unused;

  // Byte selects carry no meaning here: every access is a full word.
  assign w_unused = ^wb_sel_i;

  // Ack is withheld for one cycle after each ack, so a held strobe is served every other cycle.
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr    = w_req & wb_we_i;
  assign w_rd    = w_req & ~wb_we_i;
  assign w_wdata = wb_data_i[W-1:0];
  assign w_psr   = r_sync[g_sync_stages-1];

  assign w_edge = ((w_psr & ~r_prev & ~r_iedge) | (~w_psr & r_prev & r_iedge))
                  & r_ier & ~r_ddr;
  assign w_isr_clr = (w_wr && wb_addr_i == A_ISR) ? w_wdata : '0;

  always_comb begin
    w_rd_word = '0;
    case (wb_addr_i)
      A_PDR:   w_rd_word = r_out;
      A_DDR:   w_rd_word = r_ddr;
      A_PSR:   w_rd_word = w_psr;
      A_IER:   w_rd_word = r_ier;
      A_IEDGE: w_rd_word = r_iedge;
      A_ISR:   w_rd_word = r_isr;
      default: w_rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? 32'(w_rd_word) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out   <= '0;
      r_ddr   <= '0;
      r_ier   <= '0;
      r_iedge <= '0;
    end else if (w_wr) begin
      case (wb_addr_i)
        A_SOPR:  r_out   <= r_out | w_wdata;
        A_COPR:  r_out   <= r_out & ~w_wdata;
        A_PDR:   r_out   <= w_wdata;
        A_DDR:   r_ddr   <= w_wdata;
        A_IER:   r_ier   <= w_wdata;
        A_IEDGE: r_iedge <= w_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_sync_stages; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_in_i;
      for (int i = 1; i < g_sync_stages; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_psr;
    end
  end

  // A new edge overrides a simultaneous W1C of the same bit.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_isr <= '0;
      r_irq <= 1'b0;
    end else begin
      r_isr <= (r_isr & ~w_isr_clr) | w_edge;
      r_irq <= |(r_isr & r_ier);
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_data_o  = r_rdata;
  assign gpio_out_o = r_out;
  assign gpio_oe_o  = r_ddr;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_wb_gpio_port_irq.sv
// Bench for wb_gpio_port_irq: directed register/interrupt steps, a randomized phase
// checked against a pin-level reference model, and a narrow 8-pin instance.
module tb_wb_gpio_port_irq;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        cyc0, cyc1, stb, we;
  logic [3:0]  sel;
  logic [31:0] rd0, rd1;
  logic        ack0, ack1;
  logic [31:0] gin0, gout0, goe0;
  logic        irq0, irq1;
  logic [7:0]  gin1, gout1, goe1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  wb_gpio_port_irq #(.g_num_pins(32), .g_sync_stages(SYNC)) u_dut (
    .wb_clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdata),
    .wb_data_o(rd0), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_ack_o(ack0), .gpio_in_i(gin0), .gpio_out_o(gout0),
    .gpio_oe_o(goe0), .irq_o(irq0)
  );

  wb_gpio_port_irq #(.g_num_pins(8), .g_sync_stages(3)) u_narrow (
    .wb_clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdata),
    .wb_data_o(rd1), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_ack_o(ack1), .gpio_in_i(gin1), .gpio_out_o(gout1),
    .gpio_oe_o(goe1), .irq_o(irq1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Valid/ready: a request is cyc&stb held from a negedge until ack is seen high #1 after a posedge.
  task automatic bus(input bit inst, input bit wr, input logic [2:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    bit got;
    @(negedge clk);
    addr = a; wdata = d; we = wr; stb = 1'b1;
    if (inst) cyc1 = 1'b1; else cyc0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (inst ? ack1 : ack0) got = 1'b1;
    end
    q = inst ? rd1 : rd0;
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) check("ack_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b0, 1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus(1'b0, 1'b0, a, 32'h0, q);
    check(tag, q, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model state: registers as software sees them, plus last settled pin value.
  logic [31:0] m_out, m_ddr, m_ier, m_iedge, m_isr, m_pins;

  initial begin
    logic [31:0] v, q, rise, fall;
    int cnt, op, k;

    rst_n = 1'b0; addr = '0; wdata = '0; cyc0 = 0; cyc1 = 0; stb = 0; we = 0;
    sel = 4'hF; gin0 = '0; gin1 = '0;

    // Reset state
    cycles(3);
    check("rst_gpio_out", gout0, 32'h0);
    check("rst_gpio_oe", goe0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    check("rst_ack", {31'b0, ack0}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_read_%0d", a), 3'(a), 32'h0);

    // Ack requires cyc
    @(negedge clk); stb = 1'b1; addr = 3'd2;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ack0) cnt++; end
    stb = 1'b0;
    check("no_ack_without_cyc", 32'(cnt), 32'd0);

    // Set / clear / direct
    wr(3'd3, 32'hFFFF0000); check("ddr_oe", goe0, 32'hFFFF0000);
    wr(3'd0, 32'hFF00FF00); check("sopr_out", gout0, 32'hFF00FF00);
    wr(3'd1, 32'h55555555); check("copr_out", gout0, 32'hAA00AA00);
    wr(3'd2, 32'hDEADBEEF); check("pdr_out", gout0, 32'hDEADBEEF);
    rd_chk("pdr_read", 3'd2, 32'hDEADBEEF);
    rd_chk("sopr_reads_zero", 3'd0, 32'h0);

    // Sync latency: a read acked on the sampling edge still sees the old PSR
    gin0 = 32'h0000CAFE;
    rd_chk("psr_not_early", 3'd4, 32'h0);
    cycles(10);
    rd_chk("psr_settled", 3'd4, 32'h0000CAFE);

    // Edge interrupts (pin0 currently 0, pin1 currently 1)
    wr(3'd5, 32'h3); wr(3'd6, 32'h2); wr(3'd7, 32'hFFFFFFFF);
    cycles(2);
    check("irq_idle", {31'b0, irq0}, 32'h0);
    @(negedge clk); gin0[0] = 1'b1;
    cnt = 0;
    while (!irq0 && cnt < 20) begin @(posedge clk); cnt++; #1; end
    check("irq_latency_edges", 32'(cnt), 32'(SYNC + 2));
    gin0[1] = 1'b0; cycles(6);
    rd_chk("isr_both", 3'd7, 32'h3);
    check("irq_both", {31'b0, irq0}, 32'h1);
    wr(3'd7, 32'h1); rd_chk("isr_after_w1c1", 3'd7, 32'h2);
    cycles(2); check("irq_still_set", {31'b0, irq0}, 32'h1);
    wr(3'd7, 32'h2);
    check("irq_on_ack_edge", {31'b0, irq0}, 32'h1);
    cycles(1);
    check("irq_cleared", {31'b0, irq0}, 32'h0);

    // Masking and direction on pin 4
    gin0[4] = 1'b0; cycles(5); wr(3'd7, 32'hFFFFFFFF);
    gin0[4] = 1'b1; cycles(5);
    rd_chk("isr_ier_mask", 3'd7, 32'h0);
    gin0[4] = 1'b0; cycles(5);
    wr(3'd3, 32'hFFFF0010); wr(3'd5, 32'h13);
    gin0[4] = 1'b1; cycles(5);
    rd_chk("isr_ddr_mask", 3'd7, 32'h0);
    gin0[4] = 1'b0; cycles(5);
    wr(3'd3, 32'hFFFF0000);
    @(negedge clk); gin0[4] = 1'b1;
    @(negedge clk);
    wr(3'd7, 32'h10);
    rd_chk("isr_set_beats_w1c", 3'd7, 32'h10);

    // Randomized phase against the pin-level model
    m_out = 32'hDEADBEEF; m_pins = gin0;
    m_ddr = $urandom; m_ier = $urandom; m_iedge = $urandom;
    wr(3'd3, m_ddr); wr(3'd5, m_ier); wr(3'd6, m_iedge);
    wr(3'd7, 32'hFFFFFFFF); m_isr = '0;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          v = $urandom; gin0 = v; cycles(SYNC + 3);
          rise = v & ~m_pins; fall = ~v & m_pins;
          m_isr |= ((rise & ~m_iedge) | (fall & m_iedge)) & m_ier & ~m_ddr;
          m_pins = v;
          rd_chk("rnd_psr", 3'd4, m_pins);
          rd_chk("rnd_isr_edge", 3'd7, m_isr);
        end
        1: begin
          v = $urandom; wr(3'd7, v); m_isr &= ~v;
          rd_chk("rnd_isr_w1c", 3'd7, m_isr);
        end
        2: begin
          k = $urandom_range(0, 2); v = $urandom;
          wr(3'(k), v);
          if (k == 0) m_out |= v; else if (k == 1) m_out &= ~v; else m_out = v;
          check("rnd_gpio_out", gout0, m_out);
        end
        default: begin
          m_ier = $urandom; m_iedge = $urandom; m_ddr = $urandom;
          wr(3'd5, m_ier); wr(3'd6, m_iedge); wr(3'd3, m_ddr);
          rd_chk("rnd_ier", 3'd5, m_ier);
          check("rnd_gpio_oe", goe0, m_ddr);
        end
      endcase
      cycles(2);
      check("rnd_irq", {31'b0, irq0}, {31'b0, |(m_isr & m_ier)});
    end

    // Narrow 8-pin instance
    bus(1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, q);
    check("narrow_gpio_out", {24'b0, gout1}, 32'h000000FF);
    bus(1'b1, 1'b0, 3'd2, 32'h0, q);
    check("narrow_pdr_read", q, 32'h000000FF);
    @(negedge clk); cyc1 = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd2;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ack1) cnt++; end
    cyc1 = 1'b0; stb = 1'b0;
    check("narrow_held_stb_acks", 32'(cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
